icache: RTL
===========

# icache

Direct-mapped, read-only instruction cache between the fetch stage and the memory bus. It holds ICLN lines of ICLLEN bits indexed by physical address. A hit returns one 32-bit instruction one cycle after the request is accepted. A miss stalls, fetches a full line over the MBLEN-bit memory bus, installs it, then returns the instruction.

## Interface
Parameters:
- LINES, ICLN (4): number of cache lines; must be a power of two.
- LINE_LEN, ICLLEN (128): line width in bits; must equal MBLEN.
- ADDR_LEN, PHY_LEN (20): physical address width.
- INST_W, INST_LEN (32): instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  fetch requests the instruction at req_addr_i.
- req_addr_i  in  ADDR_LEN  byte address; bits [1:0] are ignored.
- req_ready_o  out  1  cache accepts a request this cycle.
- resp_valid_o  out  1  single-cycle pulse; resp_inst_o is valid.
- resp_inst_o  out  INST_W  returned instruction.
- flush_i  in  1  invalidate all lines (fence.i / exception).
- mem_req_o  out  1  line read request; held high until served.
- mem_addr_o  out  ADDR_LEN  line-aligned address, low 4 bits zero.
- mem_valid_i  in  1  mem_data_i is valid; one-cycle pulse.
- mem_data_i  in  LINE_LEN  full line; byte 0 is in bits [7:0].

## Operation
- Address split for 20 bits: offset [3:0], word select [3:2], index [5:4], tag [19:6] (14 bits).
- Per-line state: valid bit, tag, data.
- FSM states and transitions:
  - IDLE: `req_ready_o = !flush_i`.
  - IDLE → MISS: request accepted and it misses.
  - IDLE → IDLE: request accepted and it hits.
  - MISS → RESP: on mem_valid_i.
  - RESP → IDLE: unconditionally, after one cycle.
- Request acceptance: `req_valid_i && req_ready_o`. The address is latched into req_addr_q.
- Hit: line valid and tag matches at acceptance. The instruction is the addressed 32-bit word of the line, little-endian; word k = data[32k+31:32k].
- Miss behaviour:
  - `mem_req_o = 1` and `mem_addr_o = {req_addr_q[19:4], 4'b0}` for the whole of MISS.
  - On mem_valid_i: write data and tag to the line and set valid. Also capture the requested word into resp_inst_o.
- No backpressure on the response. Fetch must sample resp_valid_o whenever it is high.
- Flush:
  - Clears every valid bit on the edge where flush_i is high, in any state.
  - In IDLE, flush has priority: a simultaneous request is not accepted.
  - In MISS, the pending refill still completes and the instruction is still returned. The line is written but left invalid.
  - A flush in the same cycle as mem_valid_i also leaves the line invalid.
- Reset:
  - State = IDLE and all valid bits = 0.
  - req_ready_o = 1, resp_valid_o = 0, resp_inst_o = 0, mem_req_o = 0, mem_addr_o = 0.
  - Reset during MISS drops mem_req_o immediately (asynchronous). The in-flight line is discarded.
- mem_valid_i outside MISS is ignored.

## Timing
- Hit: accepted in cycle N → resp_valid_o in N+1. Back-to-back hits are supported: one per cycle.
- Miss: accepted in N → mem_req_o high from N+1 through the cycle M in which mem_valid_i = 1.
  - mem_req_o low from M+1.
  - resp_valid_o in M+1.
  - req_ready_o low from N+1 to M+1, high again at M+2.
- Minimum miss latency (mem_valid_i in N+1): response in N+2.
- Data outputs come from registers. req_ready_o is combinational from state and flush_i only.

## Structure
- Add to constants_pkg:
  - ICACHE_OFF_LEN = $clog2(ICLLEN/8)
  - ICACHE_IDX_LEN = $clog2(ICLN)
  - ICACHE_TAG_LEN = PHY_LEN − ICACHE_IDX_LEN − ICACHE_OFF_LEN
  - typedef enum icache_state_t {IDLE, MISS, RESP}
- One sub-module: icache_tag_array, holding the valid/tag storage.
  - Combinational hit lookup.
  - Synchronous write.
  - Asynchronous reset clear and synchronous flush clear.
- Data storage stays in icache.

## Test plan
- Cold miss:
  - Stimulus: after reset, req 0x01008; mem_valid_i two cycles after mem_req_o with a line holding words 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Required: mem_addr_o = 0x01000; resp_inst_o = 0x33333333 the cycle after mem_valid_i.
- Hit after fill:
  - Stimulus: reqs 0x01000, 0x01004, 0x0100C on consecutive cycles.
  - Required: responses 0x11111111, 0x22222222, 0x44444444 on consecutive cycles; mem_req_o stays 0.
- Conflict eviction:
  - Stimulus: req 0x01040 (same index 0, different tag), then 0x01000.
  - Required: both miss; mem_addr_o = 0x01040, then 0x01000.
- Flush:
  - Stimulus: flush_i for one cycle after filling line 0, with req 0x01000 held high in the same cycle.
  - Required: the request is not accepted that cycle; the next acceptance misses.
- Flush during miss:
  - Stimulus: flush_i asserted while in MISS.
  - Required: the instruction is still returned; a repeat request to the same address misses again.
- Reset mid-miss:
  - Stimulus: rst asserted while mem_req_o = 1.
  - Required: mem_req_o = 0 immediately; no resp_valid_o; a later mem_valid_i is ignored.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants, derived address-field widths and the FSM state type
// for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ICLN     = 4;
  localparam int ICLLEN   = 128;
  localparam int MBLEN    = 128;
  localparam int PHY_LEN  = 20;
  localparam int INST_LEN = 32;

  localparam int ICACHE_OFF_LEN = $clog2(ICLLEN / 8);
  localparam int ICACHE_IDX_LEN = $clog2(ICLN);
  localparam int ICACHE_TAG_LEN = PHY_LEN - ICACHE_IDX_LEN - ICACHE_OFF_LEN;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    RESP
  } icache_state_t;

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tags for the instruction cache: combinational hit lookup,
// synchronous refill write, async reset clear and synchronous flush clear.
module icache_tag_array #(
  parameter int LINES   = 4,
  parameter int IDX_LEN = 2,
  parameter int TAG_LEN = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [IDX_LEN-1:0] lookup_idx,
  input  logic [TAG_LEN-1:0] lookup_tag,
  output logic               hit,
  input  logic               wr_en,
  input  logic [IDX_LEN-1:0] wr_idx,
  input  logic [TAG_LEN-1:0] wr_tag,
  input  logic               wr_valid
);

  logic [LINES-1:0]   valid_q;
  logic [TAG_LEN-1:0] tag_q [LINES];

  assign hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

  // Flush wins over a same-edge refill so a flushed line never comes back valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[wr_idx] <= wr_valid;
      end
      if (flush) begin
        valid_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, blocking line
// refill over the memory bus on a miss, fence-style flush of all lines.
module icache
  import icache_pkg::*;
#(
  parameter int LINES    = ICLN,
  parameter int LINE_LEN = ICLLEN,
  parameter int ADDR_LEN = PHY_LEN,
  parameter int INST_W   = INST_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  input  logic [ADDR_LEN-1:0] req_addr_i,
  output logic                req_ready_o,
  output logic                resp_valid_o,
  output logic [INST_W-1:0]   resp_inst_o,
  input  logic                flush_i,
  output logic                mem_req_o,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  input  logic                mem_valid_i,
  input  logic [LINE_LEN-1:0] mem_data_i
);

  localparam int OFF_LEN  = $clog2(LINE_LEN / 8);
  localparam int IDX_LEN  = $clog2(LINES);
  localparam int TAG_LEN  = ADDR_LEN - IDX_LEN - OFF_LEN;
  localparam int WSEL_LSB = $clog2(INST_W / 8);
  localparam int WSEL_LEN = $clog2(LINE_LEN / INST_W);

  icache_state_t state_q, state_d;

  logic [ADDR_LEN-1:0] req_addr_q;
  logic                flushed_q;
  logic                resp_valid_q;
  logic [INST_W-1:0]   resp_inst_q;
  logic [LINE_LEN-1:0] data_q [LINES];

  logic                accept;
  logic                hit;
  logic                refill;
  logic [IDX_LEN-1:0]  req_idx;
  logic [TAG_LEN-1:0]  req_tag;
  logic [WSEL_LEN-1:0] req_wsel;
  logic [IDX_LEN-1:0]  q_idx;
  logic [TAG_LEN-1:0]  q_tag;
  logic [WSEL_LEN-1:0] q_wsel;
  logic                unused_addr_bits;

  assign req_idx  = req_addr_i[OFF_LEN +: IDX_LEN];
  assign req_tag  = req_addr_i[OFF_LEN+IDX_LEN +: TAG_LEN];
  assign req_wsel = req_addr_i[WSEL_LSB +: WSEL_LEN];
  assign q_idx    = req_addr_q[OFF_LEN +: IDX_LEN];
  assign q_tag    = req_addr_q[OFF_LEN+IDX_LEN +: TAG_LEN];
  assign q_wsel   = req_addr_q[WSEL_LSB +: WSEL_LEN];

  assign unused_addr_bits = ^{req_addr_i[WSEL_LSB-1:0], req_addr_q[WSEL_LSB-1:0]};

  assign accept = (state_q == IDLE) && !flush_i && req_valid_i;
  assign refill = (state_q == MISS) && mem_valid_i;

  assign resp_valid_o = resp_valid_q;
  assign resp_inst_o  = resp_inst_q;

  icache_tag_array #(
    .LINES   (LINES),
    .IDX_LEN (IDX_LEN),
    .TAG_LEN (TAG_LEN)
  ) u_tag_array (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush_i),
    .lookup_idx (req_idx),
    .lookup_tag (req_tag),
    .hit        (hit),
    .wr_en      (refill),
    .wr_idx     (q_idx),
    .wr_tag     (q_tag),
    .wr_valid   (!(flush_i || flushed_q))
  );

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    case (state_q)
      IDLE: begin
        req_ready_o = !flush_i;
        if (accept && !hit) begin
          state_d = MISS;
        end
      end
      MISS: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_addr_q[ADDR_LEN-1:OFF_LEN], {OFF_LEN{1'b0}}};
        if (mem_valid_i) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A flush seen while a refill is outstanding must keep that line invalid
  // once it lands, so remember it until the next request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      flushed_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_inst_q  <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      if (accept) begin
        req_addr_q <= req_addr_i;
        flushed_q  <= 1'b0;
      end else if (flush_i && (state_q == MISS)) begin
        flushed_q <= 1'b1;
      end
      if (accept && hit) begin
        resp_valid_q <= 1'b1;
        resp_inst_q  <= data_q[req_idx][req_wsel*INST_W +: INST_W];
      end else if (refill) begin
        resp_valid_q <= 1'b1;
        resp_inst_q  <= mem_data_i[q_wsel*INST_W +: INST_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (refill) begin
      data_q[q_idx] <= mem_data_i;
    end
  end

endmodule
